sat_div_16bit: RTL and testbench
================================

Name: sat_div_16bit

Overview:
Iterative signed 16-bit divider, the subtract-driven counterpart to the saturating add/sub datapath. It sits beside the ALU as a multi-cycle execution unit with a start/busy/done handshake. It produces quotient and remainder with truncation toward zero. Unrepresentable results saturate to the codebase saturation constants, 16'h7FFF and 16'h8000.

Parameters:
WIDTH, 16, operand/result width; iteration count equals WIDTH.

Ports:
clk      input   1      system clock; all state on rising edge
rst_n    input   1      asynchronous active-low reset
start    input   1      request; sampled only when busy==0
a        input   WIDTH  dividend, two's complement; sampled with start
b        input   WIDTH  divisor, two's complement; sampled with start
busy     output  1      operation in progress; start ignored while high
done     output  1      one-cycle pulse; q/r/dbz valid from this cycle
q        output  WIDTH  quotient; held until next done
r        output  WIDTH  remainder, sign of dividend; held until next done
dbz      output  1      divide-by-zero flag for the current result; held with q

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - busy=0, done=0, q=0, r=0, dbz=0.
  - Internal magnitude, remainder and count registers cleared.
- States:
  - IDLE: start=1 captures a, b and the sign bits.
    - b==0: go to DONE.
    - a==16'h8000 and b==16'hFFFF: go to DONE (overflow).
    - Otherwise: load |a| into the quotient shift register, |b| into the divisor register, clear partial remainder and count, go to CALC.
  - CALC: busy=1. One restoring step per cycle.
    - Shift {rem,quo} left by one.
    - Trial-subtract the divisor from the upper WIDTH+1 bits.
    - If non-negative: keep the difference and set quo LSB=1. Else: restore and set LSB=0.
    - count increments. After WIDTH steps go to FIX.
  - FIX: busy=1.
    - q = quo, negated if sign(a)!=sign(b).
    - r = rem, negated if sign(a)=1.
    - dbz=0. Go to DONE.
  - DONE: done=1, busy=0. Same start rules as IDLE (back-to-back accept). Without start, return to IDLE.
- Special results, registered on the IDLE->DONE edge (dbz takes the same edge):
  - b==0, a>=0: q=16'h7FFF, r=a, dbz=1.
  - b==0, a<0: q=16'h8000, r=a, dbz=1.
  - 16'h8000 / -1: q=16'h7FFF, r=0, dbz=0.
- Magnitudes:
  - |16'h8000| = 32768, held as unsigned WIDTH bits.
  - Partial remainder is WIDTH+1 bits so the trial subtract never wraps.
- Latency, with start sampled at edge 0:
  - Normal path: CALC occupies edges 1..WIDTH, FIX at WIDTH+1. done is high in the cycle after edge WIDTH+1, i.e. WIDTH+2 cycles after start (18 for WIDTH=16).
  - Special path: done is high in the cycle after edge 0 (latency 1).
- Handshake:
  - start with busy=1 is ignored; there is no queueing.
  - done and start in the same cycle: the new operation is accepted. done deasserts next cycle and busy rises.
  - q/r/dbz change only on the edge that raises done.
- Reset mid-operation aborts immediately with the reset values above. No done is produced for the aborted operation.
- start must be 1'b0 or 1'b1. X on start while idle is a bench error, not handled.

Decomposition:
- Shared package sat_div_pkg:
  - State enum {IDLE, CALC, FIX, DONE}.
  - Constants SAT_POS=16'h7FFF and SAT_NEG=16'h8000 (shared with the add/sub saturation logic).
  - Localparam CNT_W = $clog2(WIDTH+1).
- One natural sub-module: div_step.
  - Combinational single restoring iteration.
  - Inputs: rem, quo, divisor. Outputs: next rem, next quo.
  - Instantiated once in CALC.

Test Plan:
- a=100 (16'h0064), b=7, start 1 cycle -> busy for 17 cycles; done at cycle 18 with q=16'h000E, r=16'h0002, dbz=0.
- a=-100 (16'hFF9C), b=7 -> q=16'hFFF2 (-14), r=16'hFFFE (-2). Separately, a=100, b=-7 (16'hFFF9) -> q=16'hFFF2, r=16'h0002.
- a=16'h8000, b=16'hFFFF -> done at cycle 1, q=16'h7FFF, r=0. Separately, a=16'h8000, b=1 -> done at cycle 18, q=16'h8000, r=0.
- a=5, b=0 -> done at cycle 1, q=16'h7FFF, r=5, dbz=1. Separately, a=-5, b=0 -> q=16'h8000, r=16'hFFFB, dbz=1.
- Handshake: start a=9, b=2. Pulse start with a=50, b=5 at cycle 4 -> ignored; done at 18 with q=4, r=1. Assert start (a=50, b=5) in the done cycle -> accepted; next done 18 cycles later with q=10, r=0.
- Reset: drop rst_n at cycle 8 of a=1000, b=3 -> busy=0, done=0, q=r=0 immediately, no done later. After release, a=1000, b=3 -> q=333, r=1.

Source files
------------

// File: rtl/sat_div_pkg.sv
// Shared definitions for the iterative signed divider.
// Holds the FSM state encoding, the datapath width, the counter width
// and the saturation constants shared with the add/sub saturation logic.
package sat_div_pkg;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned CNT_W = $clog2(DIV_W + 1);

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sat_div_16bit_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
// Ports:
//   rem_i     partial remainder (WIDTH+1 bits)
//   quo_i     quotient/dividend shift register
//   divisor_i divisor magnitude
//   rem_o     next partial remainder
//   quo_o     next quotient shift register (new bit in LSB)
module div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // Shifted remainder stays below twice the divisor, so WIDTH+2 bits
  // of difference always carry a valid sign in the MSB.
  assign shifted = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
  assign trial   = {rem_i, quo_i[WIDTH-1]} - {2'b00, divisor_i};

  always_comb begin
    if (trial[WIDTH+1]) begin
      rem_o = shifted;
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = trial[WIDTH:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/sat_div_16bit.sv
// Iterative signed divider with start/busy/done handshake.
// Quotient truncates toward zero, remainder takes the dividend's sign.
// Divide-by-zero and 0x8000 / -1 saturate and complete in one cycle.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   start       request, honoured only while busy is low
//   a, b        dividend and divisor (two's complement)
//   busy        operation in progress
//   done        one-cycle completion pulse
//   q, r, dbz   quotient, remainder, divide-by-zero flag (held)
module sat_div_16bit
  import sat_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);

  state_e           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Magnitudes as unsigned; 0x8000 maps to 32768 without overflow.
  assign a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d = a[WIDTH-1];
          sb_d = b[WIDTH-1];
          if (b == '0) begin
            q_d     = a[WIDTH-1] ? SAT_NEG : SAT_POS;
            r_d     = a;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else if ((a == SAT_NEG) && (b == {WIDTH{1'b1}})) begin
            q_d     = SAT_POS;
            r_d     = '0;
            dbz_d   = 1'b0;
            state_d = DONE;
          end else begin
            quo_d   = a_mag;
            dvs_d   = b_mag;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        q_d     = (sa_q ^ sb_q) ? (~quo_q + WIDTH'(1)) : quo_q;
        r_d     = sa_q ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Registered handshake flags follow the state being entered.
    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE) && (state_q != DONE || start);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_sat_div_16bit.sv
// Self-checking bench for sat_div_16bit: directed plan cases, handshake,
// reset abort and randomized operands against an integer reference model.
module tb_sat_div_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic [15:0] r;
  logic        dbz;

  int n_cmp = 0;
  int n_err = 0;

  sat_div_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed integer division with the saturation rules.
  function automatic void ref_div(input logic [15:0] ta, input logic [15:0] tb_,
                                  output logic [15:0] eq, output logic [15:0] er,
                                  output logic edbz, output int elat);
    int sa;
    int sb;
    sa = int'($signed(ta));
    sb = int'($signed(tb_));
    if (sb == 0) begin
      eq = (sa < 0) ? 16'h8000 : 16'h7FFF;
      er = ta;
      edbz = 1'b1;
      elat = 1;
    end else if (sa == -32768 && sb == -1) begin
      eq = 16'h7FFF;
      er = 16'h0000;
      edbz = 1'b0;
      elat = 1;
    end else begin
      eq = 16'(sa / sb);
      er = 16'(sa % sb);
      edbz = 1'b0;
      elat = 18;
    end
  endfunction

  function automatic logic [15:0] pick_operand();
    logic [15:0] corners [5];
    corners[0] = 16'h0000;
    corners[1] = 16'h0001;
    corners[2] = 16'hFFFF;
    corners[3] = 16'h8000;
    corners[4] = 16'h7FFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  // Launch one operation and check latency and results. With noise set,
  // random start pulses are driven while busy and must be ignored.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input bit noise);
    logic [15:0] eq;
    logic [15:0] er;
    logic        edbz;
    int          elat;
    int          lat;
    ref_div(ta, tb_, eq, er, edbz, elat);
    @(negedge clk);
    a = ta;
    b = tb_;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    if (elat != 1) chk("busy_after_start", 32'(busy), 32'd1);
    while (!done && lat < 40) begin
      @(negedge clk);
      if (noise && busy) begin
        start = 1'($urandom_range(0, 1));
        a = 16'($urandom);
        b = 16'($urandom);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    chk($sformatf("lat %h/%h", ta, tb_), 32'(lat), 32'(elat));
    chk($sformatf("q %h/%h", ta, tb_), 32'(q), 32'(eq));
    chk($sformatf("r %h/%h", ta, tb_), 32'(r), 32'(er));
    chk($sformatf("dbz %h/%h", ta, tb_), 32'(dbz), 32'(edbz));
  endtask

  initial begin
    int lat;
    bit seen;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed plan cases.
    run_op(16'h0064, 16'h0007, 1'b0);
    run_op(16'hFF9C, 16'h0007, 1'b0);
    run_op(16'h0064, 16'hFFF9, 1'b0);
    run_op(16'h8000, 16'hFFFF, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0);
    run_op(16'h0005, 16'h0000, 1'b0);
    run_op(16'hFFFB, 16'h0000, 1'b0);
    run_op(16'h7FFF, 16'h8000, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0);

    // Handshake: start while busy is ignored; start in done cycle accepted.
    @(negedge clk);
    @(negedge clk);
    a = 16'd9;
    b = 16'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      if (lat == 4) begin
        a = 16'd50;
        b = 16'd5;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    chk("hs_lat1", 32'(lat), 32'd18);
    chk("hs_q1", 32'(q), 32'd4);
    chk("hs_r1", 32'(r), 32'd1);
    @(negedge clk);
    a = 16'd50;
    b = 16'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("hs_done_drop", 32'(done), 32'd0);
    chk("hs_busy_rise", 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("hs_lat2", 32'(lat), 32'd18);
    chk("hs_q2", 32'(q), 32'd10);
    chk("hs_r2", 32'(r), 32'd0);
    @(posedge clk);
    #1;
    chk("hs_done_pulse", 32'(done), 32'd0);

    // Reset mid-operation aborts with no later done.
    @(negedge clk);
    a = 16'd1000;
    b = 16'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_r", 32'(r), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_op(16'd1000, 16'd3, 1'b0);

    // Randomized operands with start noise while busy.
    for (int i = 0; i < 150; i++) begin
      run_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
